// File: rtl/nios2_oci_dct_packer.sv
// Debug-trace fragment packer: packs FRAG_W-bit fragments LSB-first into a
// DEPTH-slot accumulator, hands each full (or flushed partial) buffer to a held
// valid/ready output register, and signals a sticky end of test after draining.
module nios2_oci_dct_packer #(
    parameter int unsigned FRAG_W = 2,
    parameter int unsigned DEPTH  = 15,
    parameter int unsigned DROP_W = 16,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_frag_valid,
    input  logic [FRAG_W-1:0]         i_frag_data,
    output logic                      o_frag_ready,
    input  logic                      i_test_ending,
    input  logic                      i_out_ready,
    output logic                      o_out_valid,
    output logic [FRAG_W*DEPTH-1:0]   o_dct_buffer,
    output logic [CNT_W-1:0]          o_dct_count,
    output logic                      o_out_partial,
    output logic                      o_test_has_ended,
    output logic [DROP_W-1:0]         o_drop_count
);

    localparam int unsigned BUF_W = FRAG_W * DEPTH;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_ENDED = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [BUF_W-1:0]   r_acc;
    logic [BUF_W-1:0]   w_acc_next;
    logic [BUF_W-1:0]   w_acc_masked;
    logic [CNT_W-1:0]   r_acc_cnt;
    logic [CNT_W-1:0]   w_acc_cnt_next;

    logic               r_out_valid;
    logic [BUF_W-1:0]   r_dct_buffer;
    logic [CNT_W-1:0]   r_dct_count;
    logic               r_out_partial;
    logic               r_test_has_ended;
    logic [DROP_W-1:0]  r_drop_count;

    logic               w_acc_full;
    logic               w_frag_ready;
    logic               w_accept;
    logic               w_out_free;
    logic               w_xfer;

    // Handshake and transfer decode, all derived from registered state.
    always_comb begin
        w_acc_full   = (r_acc_cnt == CNT_FULL);
        w_frag_ready = (r_state == ST_RUN) && (r_acc_cnt < CNT_FULL);
        w_accept     = i_frag_valid && w_frag_ready;
        w_out_free   = !r_out_valid || i_out_ready;
        w_xfer       = (w_acc_full || ((r_state == ST_FLUSH) && (r_acc_cnt != '0)))
                       && w_out_free;
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: RUN -> FLUSH on end request, FLUSH -> ENDED once drained.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (i_test_ending) begin
                    w_state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if ((r_acc_cnt == '0) && !r_out_valid) begin
                    w_state_next = ST_ENDED;
                end
            end
            ST_ENDED: begin
                w_state_next = ST_ENDED;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    // Accumulator next value: clear on transfer, otherwise write the accepted slot.
    always_comb begin
        w_acc_next     = r_acc;
        w_acc_cnt_next = r_acc_cnt;
        if (w_xfer) begin
            w_acc_next     = '0;
            w_acc_cnt_next = '0;
        end else if (w_accept) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if (r_acc_cnt == CNT_W'(k)) begin
                    w_acc_next[k*FRAG_W +: FRAG_W] = i_frag_data;
                end
            end
            w_acc_cnt_next = r_acc_cnt + CNT_W'(1);
        end
    end

    // Outgoing image of the accumulator with unused slots forced to zero.
    always_comb begin
        w_acc_masked = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (CNT_W'(k) < r_acc_cnt) begin
                w_acc_masked[k*FRAG_W +: FRAG_W] = r_acc[k*FRAG_W +: FRAG_W];
            end
        end
    end

    // Accumulator registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_acc     <= '0;
            r_acc_cnt <= '0;
        end else begin
            r_acc     <= w_acc_next;
            r_acc_cnt <= w_acc_cnt_next;
        end
    end

    // Output register: reload on transfer, drop valid on a plain handshake.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_out_valid   <= 1'b0;
            r_dct_buffer  <= '0;
            r_dct_count   <= '0;
            r_out_partial <= 1'b0;
        end else if (w_xfer) begin
            r_out_valid   <= 1'b1;
            r_dct_buffer  <= w_acc_masked;
            r_dct_count   <= r_acc_cnt;
            r_out_partial <= (r_acc_cnt < CNT_FULL);
        end else if (r_out_valid && i_out_ready) begin
            r_out_valid   <= 1'b0;
        end
    end

    // Sticky end-of-test flag, set on entry to ENDED.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_test_has_ended <= 1'b0;
        end else if (w_state_next == ST_ENDED) begin
            r_test_has_ended <= 1'b1;
        end
    end

    // Saturating count of cycles where an offered fragment was refused.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_drop_count <= '0;
        end else if (i_frag_valid && !w_frag_ready && (r_drop_count != DROP_MAX)) begin
            r_drop_count <= r_drop_count + DROP_W'(1);
        end
    end

    assign o_frag_ready     = w_frag_ready;
    assign o_out_valid      = r_out_valid;
    assign o_dct_buffer     = r_dct_buffer;
    assign o_dct_count      = r_dct_count;
    assign o_out_partial    = r_out_partial;
    assign o_test_has_ended = r_test_has_ended;
    assign o_drop_count     = r_drop_count;

endmodule

// File: tb/tb_nios2_oci_dct_packer.sv
// Scoreboard bench for nios2_oci_dct_packer over three parameter sets.
module tb_nios2_oci_dct_packer;

    localparam int unsigned NCFG = 3;
    localparam int unsigned CFG_FW [NCFG] = '{2, 8, 2};
    localparam int unsigned CFG_DP [NCFG] = '{15, 4, 1};
    localparam logic [63:0] CFG_EXP1 [NCFG] = '{64'h15555555, 64'h44332211, 64'h1};

    typedef struct {
        logic [63:0] data;
        int          cnt;
        bit          part;
    } exp_t;

    logic clk;
    int   n_vec = 0;
    int   n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input int cfg, input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL cfg%0d %s: got %0h expected %0h at %0t", cfg, name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : gen_cfg
        localparam int unsigned FW = CFG_FW[g];
        localparam int unsigned DP = CFG_DP[g];
        localparam int unsigned CW = $clog2(DP + 1);
        localparam int unsigned BW = FW * DP;

        logic          reset, frag_valid, frag_ready, test_ending, out_ready;
        logic [FW-1:0] frag_data;
        logic          out_valid, out_partial, test_has_ended;
        logic [BW-1:0] dct_buffer;
        logic [CW-1:0] dct_count;
        logic [15:0]   drop_count;
        bit            done = 1'b0;

        nios2_oci_dct_packer #(.FRAG_W(FW), .DEPTH(DP), .DROP_W(16)) u_dut (
            .i_clk            (clk),
            .i_reset          (reset),
            .i_frag_valid     (frag_valid),
            .i_frag_data      (frag_data),
            .o_frag_ready     (frag_ready),
            .i_test_ending    (test_ending),
            .i_out_ready      (out_ready),
            .o_out_valid      (out_valid),
            .o_dct_buffer     (dct_buffer),
            .o_dct_count      (dct_count),
            .o_out_partial    (out_partial),
            .o_test_has_ended (test_has_ended),
            .o_drop_count     (drop_count)
        );

        // Reference model state: accepted fragments not yet grouped into a word.
        exp_t        q[$];
        logic [63:0] m_acc = '0;
        int          m_n = 0;
        int          m_drop = 0;
        bit          m_ending = 1'b0;
        bit          m_seen_end = 1'b0;
        bit          m_prev_reset = 1'b0;
        bit          m_hold = 1'b0;
        logic [63:0] h_buf;
        int          h_cnt;
        bit          h_part;

        function automatic logic [63:0] rep(input logic [63:0] v);
            logic [63:0] r = '0;
            logic [63:0] msk = (64'd1 << FW) - 64'd1;
            for (int k = 0; k < int'(DP); k++) r |= (v & msk) << (k * FW);
            return r;
        endfunction

        task automatic tick();
            @(posedge clk);
            #1;
        endtask

        task automatic do_reset();
            reset = 1'b1;
            tick();
            reset = 1'b0;
        endtask

        task automatic wait_ended(input int budget, output int n);
            n = 0;
            while (!test_has_ended && n < budget) begin
                tick();
                n++;
            end
            if (!test_has_ended) chk(g, "end_timeout", 0, 1);
        endtask

        // Monitor: compare against model, then advance model for the coming edge.
        always @(negedge clk) begin
            exp_t e;
            if (m_prev_reset) begin
                chk(g, "rst_valid", 64'(out_valid), 0);
                chk(g, "rst_buffer", 64'(dct_buffer), 0);
                chk(g, "rst_count", 64'(dct_count), 0);
                chk(g, "rst_partial", 64'(out_partial), 0);
                chk(g, "rst_ended", 64'(test_has_ended), 0);
                chk(g, "rst_drop", 64'(drop_count), 0);
            end else begin
                chk(g, "drop_count", 64'(drop_count), 64'(m_drop));
                if (m_ending) chk(g, "ready_after_end", 64'(frag_ready), 0);
                if (m_seen_end) begin
                    chk(g, "ended_sticky", 64'(test_has_ended), 1);
                end else if (test_has_ended) begin
                    chk(g, "ended_wo_request", 64'(m_ending), 1);
                    chk(g, "ended_undrained", 64'(q.size() + m_n), 0);
                    m_seen_end = 1'b1;
                end
                if (m_hold) begin
                    chk(g, "hold_valid", 64'(out_valid), 1);
                    chk(g, "hold_buffer", 64'(dct_buffer), h_buf);
                    chk(g, "hold_count", 64'(dct_count), 64'(h_cnt));
                    chk(g, "hold_partial", 64'(out_partial), 64'(h_part));
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        chk(g, "unexpected_word", 64'(dct_buffer), 64'hDEAD);
                    end else begin
                        e = q.pop_front();
                        chk(g, "word_buffer", 64'(dct_buffer), e.data);
                        chk(g, "word_count", 64'(dct_count), 64'(e.cnt));
                        chk(g, "word_partial", 64'(out_partial), 64'(e.part));
                    end
                end
            end
            if (reset) begin
                q.delete();
                m_acc = '0; m_n = 0; m_drop = 0;
                m_ending = 1'b0; m_seen_end = 1'b0; m_hold = 1'b0;
                m_prev_reset = 1'b1;
            end else begin
                m_prev_reset = 1'b0;
                m_hold = out_valid && !out_ready;
                h_buf = 64'(dct_buffer); h_cnt = int'(dct_count); h_part = out_partial;
                if (frag_valid && !frag_ready && m_drop < 65535) m_drop++;
                if (frag_valid && frag_ready) begin
                    m_acc |= 64'(frag_data) << (m_n * FW);
                    m_n++;
                    if (m_n == int'(DP)) begin
                        e.data = m_acc; e.cnt = m_n; e.part = 1'b0;
                        q.push_back(e);
                        m_acc = '0; m_n = 0;
                    end
                end
                if (test_ending && !m_ending) begin
                    m_ending = 1'b1;
                    if (m_n > 0) begin
                        e.data = m_acc; e.cnt = m_n; e.part = 1'b1;
                        q.push_back(e);
                        m_acc = '0; m_n = 0;
                    end
                end
            end
        end

        // Stimulus.
        initial begin
            int n, acc_cnt, d0, n3, n5;
            reset = 1'b1; frag_valid = 1'b0; frag_data = '0;
            test_ending = 1'b0; out_ready = 1'b0;
            tick(); tick();
            reset = 1'b0;

            // Back-to-back full buffer with a free output.
            out_ready = 1'b1;
            for (int k = 0; k < int'(DP); k++) begin
                frag_valid = 1'b1;
                frag_data  = (FW == 8) ? FW'((k + 1) * 17) : FW'(1);
                chk(g, "s1_ready", 64'(frag_ready), 1);
                tick();
            end
            frag_valid = 1'b0;
            tick();
            chk(g, "s1_valid", 64'(out_valid), 1);
            chk(g, "s1_count", 64'(dct_count), 64'(DP));
            chk(g, "s1_buffer", 64'(dct_buffer), CFG_EXP1[g]);
            chk(g, "s1_partial", 64'(out_partial), 0);
            chk(g, "s1_drop", 64'(drop_count), 0);
            tick(); tick();

            // Backpressure: two words fill, the rest are refused.
            do_reset();
            out_ready = 1'b0;
            acc_cnt = 0;
            for (int k = 0; k < int'(2 * DP + 10); k++) begin
                frag_valid = 1'b1;
                frag_data  = FW'(2);
                if (frag_ready) acc_cnt++;
                tick();
            end
            frag_valid = 1'b0;
            chk(g, "s2_accepts", 64'(acc_cnt), 64'(2 * DP));
            tick();
            chk(g, "s2_drop", 64'(drop_count), 10);
            chk(g, "s2_held_valid", 64'(out_valid), 1);
            chk(g, "s2_held_buffer", 64'(dct_buffer), rep(64'd2));
            out_ready = 1'b1;
            tick();
            chk(g, "s2_b2b_valid", 64'(out_valid), 1);
            tick();
            chk(g, "s2_drained", 64'(out_valid), 0);

            // Partial flush on a one-cycle end request.
            do_reset();
            out_ready = 1'b1;
            n3 = (DP > 5) ? 5 : int'(DP) - 1;
            for (int k = 0; k < n3; k++) begin
                frag_valid = 1'b1;
                frag_data  = '1;
                tick();
            end
            frag_valid  = 1'b0;
            test_ending = 1'b1;
            tick();
            test_ending = 1'b0;
            wait_ended(20, n);
            chk(g, "s3_end_latency", 64'(n), (n3 > 0) ? 64'd3 : 64'd1);
            d0 = int'(drop_count);
            frag_valid = 1'b1;
            tick();
            frag_valid = 1'b0;
            chk(g, "s3_drop_after_end", 64'(drop_count), 64'(d0 + 1));
            tick();

            // End request coincident with the completing fragment.
            do_reset();
            out_ready = 1'b1;
            for (int k = 0; k < int'(DP); k++) begin
                frag_valid  = 1'b1;
                frag_data   = FW'($urandom);
                test_ending = (k == int'(DP) - 1);
                tick();
            end
            frag_valid = 1'b0; test_ending = 1'b0;
            wait_ended(20, n);
            tick();

            // Reset while a word is held and the accumulator is partly filled.
            do_reset();
            out_ready = 1'b0;
            n5 = int'(DP) + ((DP > 7) ? 7 : int'(DP) - 1);
            for (int k = 0; k < n5; k++) begin
                frag_valid = 1'b1;
                frag_data  = FW'($urandom);
                tick();
            end
            frag_valid = 1'b0;
            do_reset();
            out_ready = 1'b1;
            for (int k = 0; k < int'(DP); k++) begin
                frag_valid = 1'b1;
                frag_data  = FW'($urandom);
                tick();
            end
            frag_valid = 1'b0;
            tick(); tick();

            // Random traffic with occasional end requests and restarts.
            for (int c = 0; c < 800; c++) begin
                reset       = test_has_ended && ($urandom_range(0, 2) == 0);
                frag_valid  = ($urandom_range(0, 3) != 0);
                frag_data   = FW'($urandom);
                out_ready   = ($urandom_range(0, 2) != 0);
                test_ending = ($urandom_range(0, 149) == 0);
                tick();
            end
            reset = 1'b0; frag_valid = 1'b0; out_ready = 1'b1;
            test_ending = 1'b1;
            tick();
            test_ending = 1'b0;
            wait_ended(100, n);
            tick(); tick();
            done = 1'b1;
        end
    end

    // Run control and summary.
    initial begin
        bit all_done = 1'b0;
        for (int c = 0; c < 30000 && !all_done; c++) begin
            @(posedge clk);
            all_done = gen_cfg[0].done && gen_cfg[1].done && gen_cfg[2].done;
        end
        if (!all_done) chk(99, "run_timeout", 0, 1);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
